// File: rtl/uart_tx.sv
// uart_tx: UART transmitter for the 4-bit CPU board.
// Each accepted word goes out as one frame on the registered line tx_o:
// a start bit, the data bits LSB first, and then a stop bit.
// Every bit lasts BAUD_COUNTS_PER_BIT clock cycles.
// Optional feature: define UART_TX_PARITY_EN to insert one even-parity bit
// between the last data bit and the stop bit.
module uart_tx #(
    parameter int unsigned UART_DATA_LENGTH           = 8,
    parameter int unsigned TX_COUNTER_BITWIDTH        = 3,
    parameter int unsigned BAUD_COUNTS_PER_BIT        = 521,
    parameter int unsigned BAUD_RATE_COUNTER_BITWIDTH = 10
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [UART_DATA_LENGTH-1:0] data_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic                        tx_o,
    output logic                        busy_o
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] BAUD_LAST =
        BAUD_RATE_COUNTER_BITWIDTH'(BAUD_COUNTS_PER_BIT - 1);
    localparam logic [TX_COUNTER_BITWIDTH-1:0] LAST_IDX =
        TX_COUNTER_BITWIDTH'(UART_DATA_LENGTH - 1);

    state_t                                state;
    state_t                                state_next;
    logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] baud_cnt;
    logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] baud_cnt_next;
    logic [TX_COUNTER_BITWIDTH-1:0]        bit_idx;
    logic [TX_COUNTER_BITWIDTH-1:0]        bit_idx_next;
    logic [UART_DATA_LENGTH-1:0]           shift_reg;
    logic [UART_DATA_LENGTH-1:0]           shift_reg_next;
    logic                                  tx_next;
    logic                                  bit_done;
`ifdef UART_TX_PARITY_EN
    logic                                  parity_bit;
    logic                                  parity_bit_next;
`endif

    assign bit_done = (baud_cnt == BAUD_LAST);
    assign ready_o  = (state == IDLE);
    assign busy_o   = ~ready_o;

    // Next-state, counter, shifter and line value; the line follows the next state so tx_o is glitch-free
    always_comb begin
        state_next     = state;
        baud_cnt_next  = baud_cnt;
        bit_idx_next   = bit_idx;
        shift_reg_next = shift_reg;
`ifdef UART_TX_PARITY_EN
        parity_bit_next = parity_bit;
`endif
        case (state)
            IDLE: begin
                if (valid_i) begin
                    shift_reg_next = data_i;
                    baud_cnt_next  = '0;
                    bit_idx_next   = '0;
                    state_next     = START;
`ifdef UART_TX_PARITY_EN
                    parity_bit_next = ^data_i;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    baud_cnt_next = '0;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_cnt_next  = '0;
                    shift_reg_next = shift_reg >> 1;
                    if (bit_idx == LAST_IDX) begin
                        bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    baud_cnt_next = '0;
                    state_next    = STOP;
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    baud_cnt_next = '0;
                    state_next    = IDLE;
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_reg_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_bit_next;
`endif
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

    // State and datapath registers; reset abandons any frame and returns the line high
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_o      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_reg_next;
            tx_o      <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_bit_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: bench for uart_tx with 4 clock cycles per bit.
// The expected line level for every cycle of a frame comes from a small
// frame model built from the UART framing rules.
module tb_uart_tx;

    localparam int B   = 4;
    localparam int LEN = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FBITS = LEN + 3;
`else
    localparam int FBITS = LEN + 2;
`endif
    localparam int FCYC = FBITS * B;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx #(
        .UART_DATA_LENGTH(LEN),
        .TX_COUNTER_BITWIDTH(3),
        .BAUD_COUNTS_PER_BIT(B),
        .BAUD_RATE_COUNTER_BITWIDTH(10)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .data_i(data),
        .valid_i(valid),
        .ready_o(ready),
        .tx_o(tx),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Bit k of the frame for word d: start, data LSB first, optional even parity, stop
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= LEN) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == LEN + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        valid = 1'b1;
        data  = 8'hA5;
        for (int c = 0; c < 2; c++) begin
            step;
            checks++;
            if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold cyc %0d got tx=%b ready=%b busy=%b want 1 1 0", c, tx, ready, busy);
            end
        end
        reset = 1'b0;
        valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step;
            checks++;
            if (tx !== 1'b1 || ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_release cyc %0d got tx=%b ready=%b want 1 1", c, tx, ready);
            end
        end
    endtask

    task automatic test_single_frame;
        logic [7:0] words[4];
        logic       exp;
        words[0] = 8'hA5;
        for (int w = 1; w < 4; w++) words[w] = 8'($urandom);
        foreach (words[w]) begin
            data  = words[w];
            valid = 1'b1;
            step;
            valid = 1'b0;
            for (int i = 0; i < FCYC; i++) begin
                exp = frame_bit(words[w], i / B);
                checks++;
                if (tx !== exp) begin
                    errors++;
                    $display("[TB] FAIL single_tx word %h cyc %0d got %b want %b", words[w], i, tx, exp);
                end
                checks++;
                if (ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL single_busy word %h cyc %0d got ready=%b busy=%b want 0 1", words[w], i, ready, busy);
                end
                data = 8'($urandom);
                step;
            end
            checks++;
            if (ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_end word %h got ready=%b tx=%b busy=%b want 1 1 0", words[w], ready, tx, busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] first;
        logic [7:0] second;
        int         busy_cycles;
        logic       exp;
        first       = 8'h00;
        second      = 8'hFF;
        busy_cycles = 0;
        data  = first;
        valid = 1'b1;
        step;
        data  = second;
        for (int i = 0; i < FCYC; i++) begin
            exp = frame_bit(first, i / B);
            if (busy === 1'b1) busy_cycles++;
            checks++;
            if (tx !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_first_tx cyc %0d got %b want %b", i, tx, exp);
            end
            step;
        end
        if (busy === 1'b1) busy_cycles++;
        checks++;
        if (ready !== 1'b1 || tx !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_handshake got ready=%b tx=%b want 1 1", ready, tx);
        end
        step;
        valid = 1'b0;
        for (int i = 0; i < FCYC; i++) begin
            exp = frame_bit(second, i / B);
            if (busy === 1'b1) busy_cycles++;
            checks++;
            if (tx !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_second_tx cyc %0d got %b want %b", i, tx, exp);
            end
            step;
        end
        checks++;
        if (busy_cycles !== 2 * FCYC) begin
            errors++;
            $display("[TB] FAIL b2b_busy_count got %0d want %0d", busy_cycles, 2 * FCYC);
        end
        checks++;
        if (ready !== 1'b1 || tx !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_end got ready=%b tx=%b want 1 1", ready, tx);
        end
    endtask

    task automatic test_ignore_busy;
        logic [7:0] word;
        int         pulse_at;
        logic       exp;
        word     = 8'h81;
        pulse_at = 3 * B + 2;
        data  = word;
        valid = 1'b1;
        step;
        valid = 1'b0;
        for (int i = 0; i < FCYC; i++) begin
            exp = frame_bit(word, i / B);
            checks++;
            if (tx !== exp) begin
                errors++;
                $display("[TB] FAIL ignore_tx cyc %0d got %b want %b", i, tx, exp);
            end
            valid = (i == pulse_at);
            data  = (i == pulse_at) ? 8'h3C : 8'($urandom);
            step;
        end
        valid = 1'b0;
        for (int i = 0; i < 2 * FCYC; i++) begin
            checks++;
            if (tx !== 1'b1 || ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL ignore_idle cyc %0d got tx=%b ready=%b want 1 1", i, tx, ready);
            end
            step;
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] words[3];
        logic       exp;
        words[0] = 8'h55;
        data  = words[0];
        valid = 1'b1;
        step;
        valid = 1'b0;
        for (int i = 0; i < 4 * B + 2; i++) begin
            exp = frame_bit(words[0], i / B);
            checks++;
            if (tx !== exp) begin
                errors++;
                $display("[TB] FAIL midreset_pre_tx cyc %0d got %b want %b", i, tx, exp);
            end
            step;
        end
        reset = 1'b1;
        step;
        reset = 1'b0;
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_after got tx=%b ready=%b busy=%b want 1 1 0", tx, ready, busy);
        end
        words[1] = 8'h0F;
        words[2] = 8'($urandom);
        for (int w = 1; w < 3; w++) begin
            data  = words[w];
            valid = 1'b1;
            step;
            valid = 1'b0;
            for (int i = 0; i < FCYC; i++) begin
                exp = frame_bit(words[w], i / B);
                checks++;
                if (tx !== exp || ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL midreset_fresh word %h cyc %0d got tx=%b ready=%b want %b 0", words[w], i, tx, ready, exp);
                end
                step;
            end
        end
    endtask

    task automatic test_random_frames;
        logic [7:0] word;
        int         gap;
        logic       exp;
        for (int f = 0; f < 6; f++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                checks++;
                if (tx !== 1'b1 || ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL random_gap frame %0d got tx=%b ready=%b want 1 1", f, tx, ready);
                end
                step;
            end
            word  = 8'($urandom);
            data  = word;
            valid = 1'b1;
            step;
            valid = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < FCYC; i++) begin
                exp = frame_bit(word, i / B);
                checks++;
                if (tx !== exp || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL random_tx word %h cyc %0d got tx=%b busy=%b want %b 1", word, i, tx, busy, exp);
                end
                data = 8'($urandom);
                step;
            end
            valid = 1'b0;
        end
        step;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] words[2];
        logic       par[2];
        int         mid;
        words[0] = 8'h07;
        par[0]   = 1'b1;
        words[1] = 8'h03;
        par[1]   = 1'b0;
        mid      = (LEN + 1) * B + B / 2;
        for (int w = 0; w < 2; w++) begin
            data  = words[w];
            valid = 1'b1;
            step;
            valid = 1'b0;
            for (int i = 0; i < FCYC; i++) begin
                if (i == mid) begin
                    checks++;
                    if (tx !== par[w]) begin
                        errors++;
                        $display("[TB] FAIL parity_bit word %h got %b want %b", words[w], tx, par[w]);
                    end
                end
                checks++;
                if (ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL parity_len word %h cyc %0d got ready=%b want 0", words[w], i, ready);
                end
                step;
            end
            checks++;
            if (ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL parity_end word %h got ready=%b want 1", words[w], ready);
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_ignore_busy;
        test_reset_mid_frame;
        test_random_frames;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
